// File: rtl/pipe_pkg.sv
// Shared widths and reset constants for the inter-stage pipeline registers
// of the 5-stage 16-bit core.
package pipe_pkg;
    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0800;

    // Encoded control field widths: ALUCtrl/SetCtrl, and BSrc/BranchCtrl/RegSrc
    localparam int CTRL3_W = 3;
    localparam int CTRL2_W = 2;
endpackage

// File: rtl/pipe_reg.sv
// One pipeline field: a D flip-flop with a synchronous, parameterised reset value.
module pipe_reg
    import pipe_pkg::*;
#(
    parameter int           W       = DATA_W,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end
endmodule

// File: rtl/pipeline_latches.sv
// IF/ID, ID/EX and EX/MEM pipeline registers; each field is an independent
// one-cycle delay with a bubble as its reset value.
module pipeline_latches
    import pipe_pkg::CTRL3_W;
    import pipe_pkg::CTRL2_W;
#(
    parameter int                DATA_W     = pipe_pkg::DATA_W,
    parameter int                REG_ADDR_W = pipe_pkg::REG_ADDR_W,
    parameter logic [DATA_W-1:0] NOP_INSTR  = pipe_pkg::NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     ifid_pc2_in,
    input  logic [DATA_W-1:0]     ifid_instruction_in,
    output logic [DATA_W-1:0]     ifid_pc2_out,
    output logic [DATA_W-1:0]     ifid_instruction_out,
    input  logic [DATA_W-1:0]     idex_pc2_in,
    input  logic [DATA_W-1:0]     idex_ReadData1_in,
    input  logic [DATA_W-1:0]     idex_ReadData2_in,
    input  logic [DATA_W-1:0]     idex_fourExtend_in,
    input  logic [DATA_W-1:0]     idex_sevenExtend_in,
    input  logic [DATA_W-1:0]     idex_shifted_in,
    input  logic [DATA_W-1:0]     idex_word_align_jump_in,
    input  logic [CTRL3_W-1:0]    idex_ALUCtrl_in,
    input  logic [CTRL3_W-1:0]    idex_SetCtrl3_in,
    input  logic [REG_ADDR_W-1:0] idex_write_reg_in,
    input  logic [CTRL2_W-1:0]    idex_BSrc_in,
    input  logic [CTRL2_W-1:0]    idex_BranchCtrl_in,
    input  logic [CTRL2_W-1:0]    idex_RegSrc_in,
    input  logic                  idex_InvA_in,
    input  logic                  idex_InvB_in,
    input  logic                  idex_branch_in,
    input  logic                  idex_SLBI_in,
    input  logic                  idex_BTR_in,
    input  logic                  idex_MemWrt_in,
    input  logic                  idex_ALUJMP_in,
    input  logic                  idex_PC_or_add_in,
    input  logic                  idex_halt_in,
    input  logic                  idex_RegWrt_in,
    output logic [DATA_W-1:0]     idex_pc2_out,
    output logic [DATA_W-1:0]     idex_ReadData1_out,
    output logic [DATA_W-1:0]     idex_ReadData2_out,
    output logic [DATA_W-1:0]     idex_fourExtend_out,
    output logic [DATA_W-1:0]     idex_sevenExtend_out,
    output logic [DATA_W-1:0]     idex_shifted_out,
    output logic [DATA_W-1:0]     idex_word_align_jump_out,
    output logic [CTRL3_W-1:0]    idex_ALUCtrl_out,
    output logic [CTRL3_W-1:0]    idex_SetCtrl3_out,
    output logic [REG_ADDR_W-1:0] idex_write_reg_out,
    output logic [CTRL2_W-1:0]    idex_BSrc_out,
    output logic [CTRL2_W-1:0]    idex_BranchCtrl_out,
    output logic [CTRL2_W-1:0]    idex_RegSrc_out,
    output logic                  idex_InvA_out,
    output logic                  idex_InvB_out,
    output logic                  idex_branch_out,
    output logic                  idex_SLBI_out,
    output logic                  idex_BTR_out,
    output logic                  idex_MemWrt_out,
    output logic                  idex_ALUJMP_out,
    output logic                  idex_PC_or_add_out,
    output logic                  idex_halt_out,
    output logic                  idex_RegWrt_out,
    input  logic [DATA_W-1:0]     exmem_ALU_in,
    input  logic [DATA_W-1:0]     exmem_BInput_in,
    input  logic [DATA_W-1:0]     exmem_SgnExt_in,
    input  logic [DATA_W-1:0]     exmem_readData2_in,
    input  logic [DATA_W-1:0]     exmem_pc2_in,
    input  logic [DATA_W-1:0]     exmem_sevenext_in,
    input  logic [REG_ADDR_W-1:0] exmem_write_reg_in,
    input  logic [CTRL2_W-1:0]    exmem_RegSrc_in,
    input  logic                  exmem_branchtake_in,
    input  logic                  exmem_branch_in,
    input  logic                  exmem_PC_or_add_in,
    input  logic                  exmem_ALUJmp_in,
    input  logic                  exmem_MemWrt_in,
    input  logic                  exmem_halt_in,
    input  logic                  exmem_RegWrt_in,
    output logic [DATA_W-1:0]     exmem_ALU_out,
    output logic [DATA_W-1:0]     exmem_BInput_out,
    output logic [DATA_W-1:0]     exmem_SgnExt_out,
    output logic [DATA_W-1:0]     exmem_readData2_out,
    output logic [DATA_W-1:0]     exmem_pc2_out,
    output logic [DATA_W-1:0]     exmem_sevenext_out,
    output logic [REG_ADDR_W-1:0] exmem_write_reg_out,
    output logic [CTRL2_W-1:0]    exmem_RegSrc_out,
    output logic                  exmem_branchtake_out,
    output logic                  exmem_branch_out,
    output logic                  exmem_PC_or_add_out,
    output logic                  exmem_ALUJmp_out,
    output logic                  exmem_MemWrt_out,
    output logic                  exmem_halt_out,
    output logic                  exmem_RegWrt_out
);
    // IF/ID: instruction resets to NOP because all-zero decodes as HALT
    pipe_reg #(.W(DATA_W)) u_ifid_pc2 (.clk(clk), .rst(rst), .d(ifid_pc2_in), .q(ifid_pc2_out));
    pipe_reg #(.W(DATA_W), .RST_VAL(NOP_INSTR)) u_ifid_instruction (.clk(clk), .rst(rst), .d(ifid_instruction_in), .q(ifid_instruction_out));

    // ID/EX
    pipe_reg #(.W(DATA_W)) u_idex_pc2 (.clk(clk), .rst(rst), .d(idex_pc2_in), .q(idex_pc2_out));
    pipe_reg #(.W(DATA_W)) u_idex_read_data1 (.clk(clk), .rst(rst), .d(idex_ReadData1_in), .q(idex_ReadData1_out));
    pipe_reg #(.W(DATA_W)) u_idex_read_data2 (.clk(clk), .rst(rst), .d(idex_ReadData2_in), .q(idex_ReadData2_out));
    pipe_reg #(.W(DATA_W)) u_idex_four_extend (.clk(clk), .rst(rst), .d(idex_fourExtend_in), .q(idex_fourExtend_out));
    pipe_reg #(.W(DATA_W)) u_idex_seven_extend (.clk(clk), .rst(rst), .d(idex_sevenExtend_in), .q(idex_sevenExtend_out));
    pipe_reg #(.W(DATA_W)) u_idex_shifted (.clk(clk), .rst(rst), .d(idex_shifted_in), .q(idex_shifted_out));
    pipe_reg #(.W(DATA_W)) u_idex_word_align_jump (.clk(clk), .rst(rst), .d(idex_word_align_jump_in), .q(idex_word_align_jump_out));
    pipe_reg #(.W(CTRL3_W)) u_idex_alu_ctrl (.clk(clk), .rst(rst), .d(idex_ALUCtrl_in), .q(idex_ALUCtrl_out));
    pipe_reg #(.W(CTRL3_W)) u_idex_set_ctrl3 (.clk(clk), .rst(rst), .d(idex_SetCtrl3_in), .q(idex_SetCtrl3_out));
    pipe_reg #(.W(REG_ADDR_W)) u_idex_write_reg (.clk(clk), .rst(rst), .d(idex_write_reg_in), .q(idex_write_reg_out));
    pipe_reg #(.W(CTRL2_W)) u_idex_bsrc (.clk(clk), .rst(rst), .d(idex_BSrc_in), .q(idex_BSrc_out));
    pipe_reg #(.W(CTRL2_W)) u_idex_branch_ctrl (.clk(clk), .rst(rst), .d(idex_BranchCtrl_in), .q(idex_BranchCtrl_out));
    pipe_reg #(.W(CTRL2_W)) u_idex_reg_src (.clk(clk), .rst(rst), .d(idex_RegSrc_in), .q(idex_RegSrc_out));
    pipe_reg #(.W(1)) u_idex_inv_a (.clk(clk), .rst(rst), .d(idex_InvA_in), .q(idex_InvA_out));
    pipe_reg #(.W(1)) u_idex_inv_b (.clk(clk), .rst(rst), .d(idex_InvB_in), .q(idex_InvB_out));
    pipe_reg #(.W(1)) u_idex_branch (.clk(clk), .rst(rst), .d(idex_branch_in), .q(idex_branch_out));
    pipe_reg #(.W(1)) u_idex_slbi (.clk(clk), .rst(rst), .d(idex_SLBI_in), .q(idex_SLBI_out));
    pipe_reg #(.W(1)) u_idex_btr (.clk(clk), .rst(rst), .d(idex_BTR_in), .q(idex_BTR_out));
    pipe_reg #(.W(1)) u_idex_mem_wrt (.clk(clk), .rst(rst), .d(idex_MemWrt_in), .q(idex_MemWrt_out));
    pipe_reg #(.W(1)) u_idex_alu_jmp (.clk(clk), .rst(rst), .d(idex_ALUJMP_in), .q(idex_ALUJMP_out));
    pipe_reg #(.W(1)) u_idex_pc_or_add (.clk(clk), .rst(rst), .d(idex_PC_or_add_in), .q(idex_PC_or_add_out));
    pipe_reg #(.W(1)) u_idex_halt (.clk(clk), .rst(rst), .d(idex_halt_in), .q(idex_halt_out));
    pipe_reg #(.W(1)) u_idex_reg_wrt (.clk(clk), .rst(rst), .d(idex_RegWrt_in), .q(idex_RegWrt_out));

    // EX/MEM
    pipe_reg #(.W(DATA_W)) u_exmem_alu (.clk(clk), .rst(rst), .d(exmem_ALU_in), .q(exmem_ALU_out));
    pipe_reg #(.W(DATA_W)) u_exmem_binput (.clk(clk), .rst(rst), .d(exmem_BInput_in), .q(exmem_BInput_out));
    pipe_reg #(.W(DATA_W)) u_exmem_sgn_ext (.clk(clk), .rst(rst), .d(exmem_SgnExt_in), .q(exmem_SgnExt_out));
    pipe_reg #(.W(DATA_W)) u_exmem_read_data2 (.clk(clk), .rst(rst), .d(exmem_readData2_in), .q(exmem_readData2_out));
    pipe_reg #(.W(DATA_W)) u_exmem_pc2 (.clk(clk), .rst(rst), .d(exmem_pc2_in), .q(exmem_pc2_out));
    pipe_reg #(.W(DATA_W)) u_exmem_sevenext (.clk(clk), .rst(rst), .d(exmem_sevenext_in), .q(exmem_sevenext_out));
    pipe_reg #(.W(REG_ADDR_W)) u_exmem_write_reg (.clk(clk), .rst(rst), .d(exmem_write_reg_in), .q(exmem_write_reg_out));
    pipe_reg #(.W(CTRL2_W)) u_exmem_reg_src (.clk(clk), .rst(rst), .d(exmem_RegSrc_in), .q(exmem_RegSrc_out));
    pipe_reg #(.W(1)) u_exmem_branchtake (.clk(clk), .rst(rst), .d(exmem_branchtake_in), .q(exmem_branchtake_out));
    pipe_reg #(.W(1)) u_exmem_branch (.clk(clk), .rst(rst), .d(exmem_branch_in), .q(exmem_branch_out));
    pipe_reg #(.W(1)) u_exmem_pc_or_add (.clk(clk), .rst(rst), .d(exmem_PC_or_add_in), .q(exmem_PC_or_add_out));
    pipe_reg #(.W(1)) u_exmem_alu_jmp (.clk(clk), .rst(rst), .d(exmem_ALUJmp_in), .q(exmem_ALUJmp_out));
    pipe_reg #(.W(1)) u_exmem_mem_wrt (.clk(clk), .rst(rst), .d(exmem_MemWrt_in), .q(exmem_MemWrt_out));
    pipe_reg #(.W(1)) u_exmem_halt (.clk(clk), .rst(rst), .d(exmem_halt_in), .q(exmem_halt_out));
    pipe_reg #(.W(1)) u_exmem_reg_wrt (.clk(clk), .rst(rst), .d(exmem_RegWrt_in), .q(exmem_RegWrt_out));
endmodule

// File: tb/tb_pipeline_latches.sv
// Bench for pipeline_latches: all fields packed into one bus so that table
// vectors, walking patterns and random traffic compare every output at once.
module tb_pipeline_latches;
    localparam int NB = 277;
    localparam int NF = 40;
    typedef logic [NB-1:0] bus_t;

    // Field widths, MSB field first, in the same order as the bus packing below
    localparam int FW[NF] = '{16, 16,
                              16, 16, 16, 16, 16, 16, 16, 3, 3, 3, 2, 2, 2,
                              1, 1, 1, 1, 1, 1, 1, 1, 1, 1,
                              16, 16, 16, 16, 16, 16, 3, 2,
                              1, 1, 1, 1, 1, 1, 1};

    typedef struct {
        logic  rst;
        bus_t  in;
        bus_t  exp;
        string name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bus_t in_bus = '1;
    bus_t out_bus;
    bus_t rst_bus;
    int   vectors = 0;
    int   miscompares = 0;

    logic [15:0] ifid_pc2_in, ifid_instruction_in, ifid_pc2_out, ifid_instruction_out;
    logic [15:0] idex_pc2_in, idex_ReadData1_in, idex_ReadData2_in, idex_fourExtend_in;
    logic [15:0] idex_sevenExtend_in, idex_shifted_in, idex_word_align_jump_in;
    logic [15:0] idex_pc2_out, idex_ReadData1_out, idex_ReadData2_out, idex_fourExtend_out;
    logic [15:0] idex_sevenExtend_out, idex_shifted_out, idex_word_align_jump_out;
    logic [2:0]  idex_ALUCtrl_in, idex_SetCtrl3_in, idex_write_reg_in;
    logic [2:0]  idex_ALUCtrl_out, idex_SetCtrl3_out, idex_write_reg_out;
    logic [1:0]  idex_BSrc_in, idex_BranchCtrl_in, idex_RegSrc_in;
    logic [1:0]  idex_BSrc_out, idex_BranchCtrl_out, idex_RegSrc_out;
    logic        idex_InvA_in, idex_InvB_in, idex_branch_in, idex_SLBI_in, idex_BTR_in;
    logic        idex_MemWrt_in, idex_ALUJMP_in, idex_PC_or_add_in, idex_halt_in, idex_RegWrt_in;
    logic        idex_InvA_out, idex_InvB_out, idex_branch_out, idex_SLBI_out, idex_BTR_out;
    logic        idex_MemWrt_out, idex_ALUJMP_out, idex_PC_or_add_out, idex_halt_out, idex_RegWrt_out;
    logic [15:0] exmem_ALU_in, exmem_BInput_in, exmem_SgnExt_in, exmem_readData2_in;
    logic [15:0] exmem_pc2_in, exmem_sevenext_in;
    logic [15:0] exmem_ALU_out, exmem_BInput_out, exmem_SgnExt_out, exmem_readData2_out;
    logic [15:0] exmem_pc2_out, exmem_sevenext_out;
    logic [2:0]  exmem_write_reg_in, exmem_write_reg_out;
    logic [1:0]  exmem_RegSrc_in, exmem_RegSrc_out;
    logic        exmem_branchtake_in, exmem_branch_in, exmem_PC_or_add_in, exmem_ALUJmp_in;
    logic        exmem_MemWrt_in, exmem_halt_in, exmem_RegWrt_in;
    logic        exmem_branchtake_out, exmem_branch_out, exmem_PC_or_add_out, exmem_ALUJmp_out;
    logic        exmem_MemWrt_out, exmem_halt_out, exmem_RegWrt_out;

    assign {ifid_pc2_in, ifid_instruction_in,
            idex_pc2_in, idex_ReadData1_in, idex_ReadData2_in, idex_fourExtend_in,
            idex_sevenExtend_in, idex_shifted_in, idex_word_align_jump_in,
            idex_ALUCtrl_in, idex_SetCtrl3_in, idex_write_reg_in,
            idex_BSrc_in, idex_BranchCtrl_in, idex_RegSrc_in,
            idex_InvA_in, idex_InvB_in, idex_branch_in, idex_SLBI_in, idex_BTR_in,
            idex_MemWrt_in, idex_ALUJMP_in, idex_PC_or_add_in, idex_halt_in, idex_RegWrt_in,
            exmem_ALU_in, exmem_BInput_in, exmem_SgnExt_in, exmem_readData2_in,
            exmem_pc2_in, exmem_sevenext_in, exmem_write_reg_in, exmem_RegSrc_in,
            exmem_branchtake_in, exmem_branch_in, exmem_PC_or_add_in, exmem_ALUJmp_in,
            exmem_MemWrt_in, exmem_halt_in, exmem_RegWrt_in} = in_bus;

    assign out_bus = {ifid_pc2_out, ifid_instruction_out,
            idex_pc2_out, idex_ReadData1_out, idex_ReadData2_out, idex_fourExtend_out,
            idex_sevenExtend_out, idex_shifted_out, idex_word_align_jump_out,
            idex_ALUCtrl_out, idex_SetCtrl3_out, idex_write_reg_out,
            idex_BSrc_out, idex_BranchCtrl_out, idex_RegSrc_out,
            idex_InvA_out, idex_InvB_out, idex_branch_out, idex_SLBI_out, idex_BTR_out,
            idex_MemWrt_out, idex_ALUJMP_out, idex_PC_or_add_out, idex_halt_out, idex_RegWrt_out,
            exmem_ALU_out, exmem_BInput_out, exmem_SgnExt_out, exmem_readData2_out,
            exmem_pc2_out, exmem_sevenext_out, exmem_write_reg_out, exmem_RegSrc_out,
            exmem_branchtake_out, exmem_branch_out, exmem_PC_or_add_out, exmem_ALUJmp_out,
            exmem_MemWrt_out, exmem_halt_out, exmem_RegWrt_out};

    pipeline_latches dut (
        .clk(clk), .rst(rst),
        .ifid_pc2_in(ifid_pc2_in), .ifid_instruction_in(ifid_instruction_in),
        .ifid_pc2_out(ifid_pc2_out), .ifid_instruction_out(ifid_instruction_out),
        .idex_pc2_in(idex_pc2_in), .idex_ReadData1_in(idex_ReadData1_in),
        .idex_ReadData2_in(idex_ReadData2_in), .idex_fourExtend_in(idex_fourExtend_in),
        .idex_sevenExtend_in(idex_sevenExtend_in), .idex_shifted_in(idex_shifted_in),
        .idex_word_align_jump_in(idex_word_align_jump_in), .idex_ALUCtrl_in(idex_ALUCtrl_in),
        .idex_SetCtrl3_in(idex_SetCtrl3_in), .idex_write_reg_in(idex_write_reg_in),
        .idex_BSrc_in(idex_BSrc_in), .idex_BranchCtrl_in(idex_BranchCtrl_in),
        .idex_RegSrc_in(idex_RegSrc_in), .idex_InvA_in(idex_InvA_in), .idex_InvB_in(idex_InvB_in),
        .idex_branch_in(idex_branch_in), .idex_SLBI_in(idex_SLBI_in), .idex_BTR_in(idex_BTR_in),
        .idex_MemWrt_in(idex_MemWrt_in), .idex_ALUJMP_in(idex_ALUJMP_in),
        .idex_PC_or_add_in(idex_PC_or_add_in), .idex_halt_in(idex_halt_in),
        .idex_RegWrt_in(idex_RegWrt_in),
        .idex_pc2_out(idex_pc2_out), .idex_ReadData1_out(idex_ReadData1_out),
        .idex_ReadData2_out(idex_ReadData2_out), .idex_fourExtend_out(idex_fourExtend_out),
        .idex_sevenExtend_out(idex_sevenExtend_out), .idex_shifted_out(idex_shifted_out),
        .idex_word_align_jump_out(idex_word_align_jump_out), .idex_ALUCtrl_out(idex_ALUCtrl_out),
        .idex_SetCtrl3_out(idex_SetCtrl3_out), .idex_write_reg_out(idex_write_reg_out),
        .idex_BSrc_out(idex_BSrc_out), .idex_BranchCtrl_out(idex_BranchCtrl_out),
        .idex_RegSrc_out(idex_RegSrc_out), .idex_InvA_out(idex_InvA_out), .idex_InvB_out(idex_InvB_out),
        .idex_branch_out(idex_branch_out), .idex_SLBI_out(idex_SLBI_out), .idex_BTR_out(idex_BTR_out),
        .idex_MemWrt_out(idex_MemWrt_out), .idex_ALUJMP_out(idex_ALUJMP_out),
        .idex_PC_or_add_out(idex_PC_or_add_out), .idex_halt_out(idex_halt_out),
        .idex_RegWrt_out(idex_RegWrt_out),
        .exmem_ALU_in(exmem_ALU_in), .exmem_BInput_in(exmem_BInput_in),
        .exmem_SgnExt_in(exmem_SgnExt_in), .exmem_readData2_in(exmem_readData2_in),
        .exmem_pc2_in(exmem_pc2_in), .exmem_sevenext_in(exmem_sevenext_in),
        .exmem_write_reg_in(exmem_write_reg_in), .exmem_RegSrc_in(exmem_RegSrc_in),
        .exmem_branchtake_in(exmem_branchtake_in), .exmem_branch_in(exmem_branch_in),
        .exmem_PC_or_add_in(exmem_PC_or_add_in), .exmem_ALUJmp_in(exmem_ALUJmp_in),
        .exmem_MemWrt_in(exmem_MemWrt_in), .exmem_halt_in(exmem_halt_in),
        .exmem_RegWrt_in(exmem_RegWrt_in),
        .exmem_ALU_out(exmem_ALU_out), .exmem_BInput_out(exmem_BInput_out),
        .exmem_SgnExt_out(exmem_SgnExt_out), .exmem_readData2_out(exmem_readData2_out),
        .exmem_pc2_out(exmem_pc2_out), .exmem_sevenext_out(exmem_sevenext_out),
        .exmem_write_reg_out(exmem_write_reg_out), .exmem_RegSrc_out(exmem_RegSrc_out),
        .exmem_branchtake_out(exmem_branchtake_out), .exmem_branch_out(exmem_branch_out),
        .exmem_PC_or_add_out(exmem_PC_or_add_out), .exmem_ALUJmp_out(exmem_ALUJmp_out),
        .exmem_MemWrt_out(exmem_MemWrt_out), .exmem_halt_out(exmem_halt_out),
        .exmem_RegWrt_out(exmem_RegWrt_out)
    );

    always #5 clk = ~clk;

    // Place value v (truncated to the field width) into field idx of the bus
    function automatic bus_t fld(input int idx, input logic [15:0] v);
        int   off;
        bus_t m;
        off = NB;
        for (int i = 0; i <= idx; i++) off -= FW[i];
        m = '0;
        m[15:0] = v;
        m = m & ((bus_t'(1) << FW[idx]) - bus_t'(1));
        return m << off;
    endfunction

    function automatic bus_t rand_bus();
        bus_t r;
        r = '0;
        for (int i = 0; i < 9; i++) r = (r << 32) | bus_t'($urandom());
        return r;
    endfunction

    task automatic check(input string name, input bus_t exp);
        vectors++;
        if (out_bus !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, out_bus, exp);
        end
    endtask

    // Drive at negedge, let one posedge capture, sample 1 time unit later
    task automatic step(input logic r, input bus_t in_v, input bus_t exp, input string name);
        @(negedge clk);
        rst = r;
        in_bus = in_v;
        @(posedge clk);
        #1;
        check(name, exp);
    endtask

    initial begin
        vec_t vecs[9];
        bus_t p;
        logic r;

        rst_bus = fld(1, 16'h0800);

        vecs[0] = '{1'b1, '1, rst_bus, "reset_edge1"};
        vecs[1] = '{1'b1, '1, rst_bus, "reset_edge2"};
        p = fld(0, 16'h0002) | fld(1, 16'hC001);
        vecs[2] = '{1'b0, p, p, "ifid_capture"};
        p = fld(0, 16'h0002) | fld(1, 16'h0800);
        vecs[3] = '{1'b0, p, p, "ifid_nop"};
        vecs[4] = '{1'b0, fld(25, 16'h1234), fld(25, 16'h1234), "exmem_alu_1"};
        vecs[5] = '{1'b0, fld(25, 16'h5678), fld(25, 16'h5678), "exmem_alu_2"};
        vecs[6] = '{1'b0, fld(25, 16'h9ABC), fld(25, 16'h9ABC), "exmem_alu_3"};
        vecs[7] = '{1'b1, fld(1, 16'h0000) | fld(38, 16'h1), rst_bus, "reset_priority"};
        p = fld(1, 16'h0000) | fld(38, 16'h1) | fld(24, 16'h1);
        vecs[8] = '{1'b0, p, p, "resume_after_reset"};

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].rst, vecs[i].in, vecs[i].exp, vecs[i].name);
            // Inputs change mid-cycle without a clock edge: outputs must hold
            #3;
            in_bus = rand_bus();
            #1;
            check({vecs[i].name, "_hold"}, vecs[i].exp);
        end

        // Walking all-ones per field: detects cross-wired or mis-sized fields
        for (int f = 0; f < NF; f++) begin
            step(1'b0, fld(f, 16'hFFFF), fld(f, 16'hFFFF), $sformatf("walk_field_%0d", f));
        end

        // Mid-stream reset with every stage loaded, then resumed capture
        step(1'b0, '1, '1, "load_all_ones");
        step(1'b1, rand_bus(), rst_bus, "mid_stream_reset");
        p = rand_bus();
        step(1'b0, p, p, "post_reset_capture");

        // Random traffic: each output is its input from the previous edge, or the reset image
        for (int n = 0; n < 300; n++) begin
            r = ($urandom_range(0, 15) == 0);
            p = rand_bus();
            step(r, p, r ? rst_bus : p, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion, expected finish before 100000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pipeline_latches.md
Name: pipeline_latches

Overview:
- Holds the three inter-stage pipeline registers of the 5-stage 16-bit core: IF/ID, ID/EX and EX/MEM.
- Each stage's `_in` fields are captured on the rising clock edge and presented on the matching `_out` fields for the next stage.
- Sits between fetch, decode, execute and memory. It contains no logic beyond the registers and their reset values.

Parameters:
- DATA_W, 16: datapath width for PC, instruction, operands, immediates and ALU result.
- REG_ADDR_W, 3: register-file address width.
- NOP_INSTR, 16'h0800: IF/ID instruction reset value.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- Every field below exists as a `<field>_in` input and a `<field>_out` output of the same width.
- IF/ID fields:
  - ifid_pc2  16  PC+2
  - ifid_instruction  16
- ID/EX 16-bit fields:
  - idex_pc2
  - idex_ReadData1
  - idex_ReadData2
  - idex_fourExtend
  - idex_sevenExtend
  - idex_shifted
  - idex_word_align_jump
- ID/EX 3-bit fields:
  - idex_ALUCtrl
  - idex_SetCtrl3
  - idex_write_reg
- ID/EX 2-bit fields:
  - idex_BSrc
  - idex_BranchCtrl
  - idex_RegSrc
- ID/EX 1-bit fields:
  - idex_InvA
  - idex_InvB
  - idex_branch
  - idex_SLBI
  - idex_BTR
  - idex_MemWrt
  - idex_ALUJMP
  - idex_PC_or_add
  - idex_halt
  - idex_RegWrt
- EX/MEM 16-bit fields:
  - exmem_ALU
  - exmem_BInput
  - exmem_SgnExt
  - exmem_readData2
  - exmem_pc2
  - exmem_sevenext
- EX/MEM 3-bit fields:
  - exmem_write_reg
- EX/MEM 2-bit fields:
  - exmem_RegSrc
- EX/MEM 1-bit fields:
  - exmem_branchtake
  - exmem_branch
  - exmem_PC_or_add
  - exmem_ALUJmp
  - exmem_MemWrt
  - exmem_halt
  - exmem_RegWrt

Behaviour:
- Every `_out` is a plain D flip-flop of its `_in`.
  - Latency is exactly one clk cycle per stage.
  - There is no combinational path from any input to any output.
- Reset: synchronous on the posedge where rst=1, and takes priority over capture.
  - All outputs become 0, except ifid_instruction_out, which becomes NOP_INSTR (16'h0800).
  - Zero is never used as the instruction reset value, because 16'h0000 decodes as HALT.
  - After reset, every stage therefore carries a bubble: RegWrt=0, MemWrt=0, halt=0, branch=0, branchtake=0.
- Stages are independent.
  - There is no internal chaining: the integrating top wires idex_pc2_in from ifid_pc2_out, and so on.
  - A value driven into IF/ID appears on ID/EX only if the top routes it there.
- No enable, stall or flush ports: every stage updates on every clock edge when rst=0.
- Reset asserted mid-stream clears all three stages on the same edge. The first post-reset capture happens on the next edge with rst=0.
- Outputs hold their value between edges and are unaffected by X or glitches on the inputs except at the sampling edge.
- Widths are carried through unchanged; no truncation or extension inside the block.

Decomposition:
- Shared package `pipe_pkg`:
  - constants DATA_W, REG_ADDR_W and NOP_INSTR (16'h0800);
  - widths of the encoded control fields: ALUCtrl/SetCtrl 3, BSrc/BranchCtrl/RegSrc 2.
- One generic sub-module `pipe_reg` (parameters W and RST_VAL; ports clk, rst, d, q).
  - Each field is one `pipe_reg` instance.
  - Instances are grouped into the three stage sections inside pipeline_latches.

Test Plan:
- Reset: hold rst=1 for 2 edges with all inputs at 16'hFFFF / all-ones.
  - ifid_instruction_out = 16'h0800; every other output = 0.
- IF/ID capture: rst=0, drive ifid_instruction_in=16'hC001 and ifid_pc2_in=16'h0002 at negedge.
  - Both appear on the outputs after the next posedge and hold until the following edge.
  - Next cycle, drive 16'h0800 → the output becomes 16'h0800 one edge later.
- ID/EX walking pattern: for each field in turn, drive all-ones with all other fields 0.
  - Only that field's output is all-ones after one edge, e.g. idex_write_reg_out=3'b111, idex_ReadData1_out=16'hFFFF.
  - This checks that no field is cross-wired.
- EX/MEM pipeline: drive exmem_ALU_in = 16'h1234, 16'h5678, 16'h9ABC on consecutive cycles.
  - exmem_ALU_out follows one cycle later, in the same order.
- Mid-operation reset: with nonzero data in all stages (exmem_halt_out=1, idex_RegWrt_out=1), assert rst for one edge.
  - All outputs clear to their reset values on that edge, with the instruction output = 16'h0800.
  - Capture resumes on the next edge.
- Reset priority: assert rst together with changing inputs → outputs still take the reset values.
